// File: rtl/writeback_stage.sv
// Writeback stage: registers MEM results, extracts load data and drives the register-file write port / decode forward path.
// Latency: one cycle; every output is a flop, there is no input-to-output combinational path.
// Backpressure: i_stall holds the slot (its write stays asserted), and i_flush overrides it by loading a bubble.
// Optional: define WB_RETIRE_CNT_EN to build the retire counter; otherwise o_retired_cnt is tied to 0.
module writeback_stage #(
    parameter int         CNT_W    = 32,
    parameter logic [4:0] ZERO_REG = 5'd0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_stall,
    input  logic             i_flush,
    input  logic             i_valid,
    input  logic             i_c_regWrite,
    input  logic             i_c_memToReg,
    input  logic             i_c_link,
    input  logic [4:0]       i_wrAddr,
    input  logic [31:0]      i_ALUres,
    input  logic [31:0]      i_mem,
    input  logic [31:0]      i_link_pc,
    input  logic [1:0]       i_ld_size,
    input  logic             i_ld_unsigned,
    input  logic             i_exception,
    output logic             o_c_regWrite,
    output logic [4:0]       o_wrAddr,
    output logic [31:0]      o_wrDataToReg,
    output logic             o_wb_valid,
    output logic             o_misaligned,
    output logic [CNT_W-1:0] o_retired_cnt
);

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;

    logic [1:0]  ld_off;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;
    logic        mis_raw;
    logic        mis_nxt;
    logic        valid_nxt;
    logic        we_nxt;
    logic [31:0] wr_data_nxt;
    logic        capture;

    assign ld_off  = i_ALUres[1:0];
    // A flush always wins over a stall; only a plain cycle takes new MEM state.
    assign capture = !i_flush && !i_stall;

    // Little-endian load lane extraction with sign/zero extension, plus alignment check.
    always_comb begin
        ld_byte = 8'h00;
        case (ld_off)
            2'd0:    ld_byte = i_mem[7:0];
            2'd1:    ld_byte = i_mem[15:8];
            2'd2:    ld_byte = i_mem[23:16];
            default: ld_byte = i_mem[31:24];
        endcase

        // Odd half offsets are misaligned, so only bit 1 chooses the lane.
        ld_half = ld_off[1] ? i_mem[31:16] : i_mem[15:0];

        ld_data = i_mem;
        case (i_ld_size)
            SZ_BYTE: ld_data = i_ld_unsigned ? {24'h000000, ld_byte}
                                             : {{24{ld_byte[7]}}, ld_byte};
            SZ_HALF: ld_data = i_ld_unsigned ? {16'h0000, ld_half}
                                             : {{16{ld_half[15]}}, ld_half};
            default: ld_data = i_mem;   // word, and reserved size 3 behaves as word
        endcase

        mis_raw = 1'b0;
        if (i_c_memToReg) begin
            if (i_ld_size == SZ_HALF)
                mis_raw = ld_off[0];
            else if (i_ld_size[1])
                mis_raw = (ld_off != 2'd0);
        end
    end

    // Next-state slot control: what a capture would load into the WB registers.
    always_comb begin
        mis_nxt   = i_valid && mis_raw;
        valid_nxt = i_valid && !i_exception && !mis_raw;
        we_nxt    = valid_nxt && i_c_regWrite && (i_wrAddr != ZERO_REG);
        if (i_c_link)
            wr_data_nxt = i_link_pc;
        else if (i_c_memToReg)
            wr_data_nxt = ld_data;
        else
            wr_data_nxt = i_ALUres;
    end

    // WB slot registers: flush empties the slot, stall holds it, otherwise capture.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_c_regWrite  <= 1'b0;
            o_wrAddr      <= 5'd0;
            o_wrDataToReg <= 32'd0;
            o_wb_valid    <= 1'b0;
            o_misaligned  <= 1'b0;
        end else if (i_flush) begin
            // Address/data are don't-care in a bubble; holding them saves toggles.
            o_c_regWrite <= 1'b0;
            o_wb_valid   <= 1'b0;
            o_misaligned <= 1'b0;
        end else if (i_stall) begin
            // The held write is re-applied every cycle, which is harmless; the
            // misalignment event must not repeat, so it drops after one cycle.
            o_misaligned <= 1'b0;
        end else begin
            o_c_regWrite  <= we_nxt;
            o_wrAddr      <= i_wrAddr;
            o_wrDataToReg <= wr_data_nxt;
            o_wb_valid    <= valid_nxt;
            o_misaligned  <= mis_nxt;
        end
    end

`ifdef WB_RETIRE_CNT_EN
    logic [CNT_W-1:0] retired_q;

    // Count each instruction once, at the edge that brings it into the slot.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            retired_q <= '0;
        else if (capture && valid_nxt)
            retired_q <= retired_q + CNT_W'(1);
    end

    assign o_retired_cnt = retired_q;
`else
    assign o_retired_cnt = '0;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage, built with an 8-bit retire counter so wrap is reachable.
module tb_writeback_stage;

`ifdef WB_RETIRE_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_stall, i_flush, i_valid;
    logic        i_c_regWrite, i_c_memToReg, i_c_link;
    logic [4:0]  i_wrAddr;
    logic [31:0] i_ALUres, i_mem, i_link_pc;
    logic [1:0]  i_ld_size;
    logic        i_ld_unsigned, i_exception;
    logic        o_c_regWrite;
    logic [4:0]  o_wrAddr;
    logic [31:0] o_wrDataToReg;
    logic        o_wb_valid, o_misaligned;
    logic [7:0]  o_retired_cnt;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_cnt = 8'd0;

    writeback_stage #(.CNT_W(8), .ZERO_REG(5'd0)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_stall(i_stall), .i_flush(i_flush),
        .i_valid(i_valid), .i_c_regWrite(i_c_regWrite), .i_c_memToReg(i_c_memToReg),
        .i_c_link(i_c_link), .i_wrAddr(i_wrAddr), .i_ALUres(i_ALUres), .i_mem(i_mem),
        .i_link_pc(i_link_pc), .i_ld_size(i_ld_size), .i_ld_unsigned(i_ld_unsigned),
        .i_exception(i_exception), .o_c_regWrite(o_c_regWrite), .o_wrAddr(o_wrAddr),
        .o_wrDataToReg(o_wrDataToReg), .o_wb_valid(o_wb_valid),
        .o_misaligned(o_misaligned), .o_retired_cnt(o_retired_cnt)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one edge and sample 1ns after it.
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic bump();
        if (CNT_ON) exp_cnt = exp_cnt + 8'd1;
    endtask

    task automatic set_alu(input logic [4:0] addr, input logic [31:0] res);
        i_valid = 1'b1; i_c_regWrite = 1'b1; i_c_memToReg = 1'b0; i_c_link = 1'b0;
        i_exception = 1'b0; i_wrAddr = addr; i_ALUres = res; i_ld_size = 2'd2;
        i_ld_unsigned = 1'b0;
    endtask

    task automatic set_load(input logic [4:0] addr, input logic [31:0] mem, input logic [1:0] off,
                            input logic [1:0] size, input logic uns);
        i_valid = 1'b1; i_c_regWrite = 1'b1; i_c_memToReg = 1'b1; i_c_link = 1'b0;
        i_exception = 1'b0; i_wrAddr = addr; i_ALUres = {30'h00001000, off}; i_mem = mem;
        i_ld_size = size; i_ld_unsigned = uns;
    endtask

    task automatic chk_load(input string tag, input logic [31:0] exp_data);
        chk({tag, ".we"}, {31'd0, o_c_regWrite}, 32'd1);
        chk({tag, ".data"}, o_wrDataToReg, exp_data);
        chk({tag, ".cnt"}, {24'd0, o_retired_cnt}, {24'd0, exp_cnt});
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".we"}, {31'd0, o_c_regWrite}, 32'd0);
        chk({tag, ".addr"}, {27'd0, o_wrAddr}, 32'd0);
        chk({tag, ".data"}, o_wrDataToReg, 32'd0);
        chk({tag, ".valid"}, {31'd0, o_wb_valid}, 32'd0);
        chk({tag, ".mis"}, {31'd0, o_misaligned}, 32'd0);
        chk({tag, ".cnt"}, {24'd0, o_retired_cnt}, 32'd0);
    endtask

    initial begin
        int n;
        // Reset with a live instruction presented.
        i_rst_n = 1'b0; i_stall = 1'b0; i_flush = 1'b0;
        i_mem = 32'hDEADBEEF; i_link_pc = 32'h0;
        set_alu(5'd3, 32'hCAFE0000);
        repeat (2) step();
        chk_zero("rst");

        // First capture after release.
        i_rst_n = 1'b1;
        set_alu(5'd5, 32'h00001234);
        step(); bump();
        chk("alu.we", {31'd0, o_c_regWrite}, 32'd1);
        chk("alu.addr", {27'd0, o_wrAddr}, 32'd5);
        chk("alu.data", o_wrDataToReg, 32'h00001234);
        chk("alu.valid", {31'd0, o_wb_valid}, 32'd1);
        chk("alu.cnt", {24'd0, o_retired_cnt}, {24'd0, exp_cnt});

        // Loads from mem = 0x80FF7F01.
        set_load(5'd6, 32'h80FF7F01, 2'd2, 2'd0, 1'b0); step(); bump();
        chk_load("lb_off2", 32'hFFFFFFFF);
        set_load(5'd6, 32'h80FF7F01, 2'd2, 2'd0, 1'b1); step(); bump();
        chk_load("lbu_off2", 32'h000000FF);
        set_load(5'd6, 32'h80FF7F01, 2'd3, 2'd0, 1'b0); step(); bump();
        chk_load("lb_off3", 32'hFFFFFF80);
        set_load(5'd6, 32'h80FF7F01, 2'd1, 2'd0, 1'b0); step(); bump();
        chk_load("lb_off1", 32'h0000007F);
        set_load(5'd6, 32'h80FF7F01, 2'd2, 2'd1, 1'b0); step(); bump();
        chk_load("lh_off2", 32'hFFFF80FF);
        set_load(5'd6, 32'h80FF7F01, 2'd0, 2'd1, 1'b1); step(); bump();
        chk_load("lhu_off0", 32'h00007F01);
        set_load(5'd6, 32'h80FF7F01, 2'd0, 2'd2, 1'b0); step(); bump();
        chk_load("lw", 32'h80FF7F01);
        set_load(5'd6, 32'h12345678, 2'd0, 2'd3, 1'b0); step(); bump();
        chk_load("lw_rsvd", 32'h12345678);

        // Misaligned half: squashed, single-cycle pulse, pulse dropped during stall.
        set_load(5'd7, 32'h80FF7F01, 2'd1, 2'd1, 1'b0); step();
        chk("mis_h.we", {31'd0, o_c_regWrite}, 32'd0);
        chk("mis_h.valid", {31'd0, o_wb_valid}, 32'd0);
        chk("mis_h.mis", {31'd0, o_misaligned}, 32'd1);
        chk("mis_h.cnt", {24'd0, o_retired_cnt}, {24'd0, exp_cnt});
        i_stall = 1'b1; step();
        chk("mis_stall.mis", {31'd0, o_misaligned}, 32'd0);
        chk("mis_stall.valid", {31'd0, o_wb_valid}, 32'd0);
        i_stall = 1'b0;
        // Misaligned word.
        set_load(5'd7, 32'h80FF7F01, 2'd2, 2'd2, 1'b0); step();
        chk("mis_w.mis", {31'd0, o_misaligned}, 32'd1);
        chk("mis_w.we", {31'd0, o_c_regWrite}, 32'd0);
        i_valid = 1'b0; step();
        chk("bubble.mis", {31'd0, o_misaligned}, 32'd0);
        chk("bubble.valid", {31'd0, o_wb_valid}, 32'd0);
        chk("bubble.cnt", {24'd0, o_retired_cnt}, {24'd0, exp_cnt});

        // jal link write.
        set_alu(5'd31, 32'h0000BEEF); i_c_link = 1'b1; i_link_pc = 32'h00400008;
        step(); bump();
        chk("jal.addr", {27'd0, o_wrAddr}, 32'd31);
        chk_load("jal", 32'h00400008);

        // Zero register: retires but never writes.
        set_alu(5'd0, 32'h00000077); step(); bump();
        chk("r0.we", {31'd0, o_c_regWrite}, 32'd0);
        chk("r0.valid", {31'd0, o_wb_valid}, 32'd1);
        chk("r0.cnt", {24'd0, o_retired_cnt}, {24'd0, exp_cnt});

        // Stall three cycles with different inputs presented: slot holds, counted once.
        set_alu(5'd7, 32'h0000AAAA); step(); bump();
        i_stall = 1'b1; set_alu(5'd9, 32'h00005555);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall.we", {31'd0, o_c_regWrite}, 32'd1);
            chk("stall.addr", {27'd0, o_wrAddr}, 32'd7);
            chk("stall.data", o_wrDataToReg, 32'h0000AAAA);
            chk("stall.cnt", {24'd0, o_retired_cnt}, {24'd0, exp_cnt});
        end

        // Stall together with flush gives a bubble.
        i_flush = 1'b1; step();
        chk("sflush.we", {31'd0, o_c_regWrite}, 32'd0);
        chk("sflush.valid", {31'd0, o_wb_valid}, 32'd0);
        chk("sflush.cnt", {24'd0, o_retired_cnt}, {24'd0, exp_cnt});
        i_flush = 1'b0; i_stall = 1'b0;

        // Exception squashes the write and the retire.
        set_alu(5'd8, 32'h00000001); i_exception = 1'b1; step();
        chk("exc.we", {31'd0, o_c_regWrite}, 32'd0);
        chk("exc.valid", {31'd0, o_wb_valid}, 32'd0);
        chk("exc.cnt", {24'd0, o_retired_cnt}, {24'd0, exp_cnt});

        // Drive the 8-bit counter to wrap back to 0, then one more.
        set_alu(5'd1, 32'h00000002);
        n = 256 - int'(exp_cnt);
        for (int k = 0; k < n; k++) begin
            step(); bump();
        end
        chk("wrap.cnt0", {24'd0, o_retired_cnt}, 32'd0);
        step(); bump();
        chk("wrap.cnt1", {24'd0, o_retired_cnt}, {24'd0, exp_cnt});

        // Async reset asserted mid-cycle while stalled and flushing.
        i_stall = 1'b1; i_flush = 1'b1;
        #2 i_rst_n = 1'b0;
        #1;
        chk_zero("arst");
        step();
        chk_zero("arst_hold");
        i_rst_n = 1'b1; i_stall = 1'b0; i_flush = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final pipeline stage; the writer side of the register-file port that decode reads.
- Registers MEM-stage results and selects ALU result, load data or link address.
- Performs byte/half/word load extraction with sign or zero extension.
- Drives the register-file write port (write enable, write address, write data) back into decode; the same bus serves decode's fourth forwarding source. Counts retired instructions.

Parameters:
- CNT_W, 32, width of retire counter (valid range 8..64)
- ZERO_REG, 0, register index whose writes are always suppressed

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_stall  in  1  hold WB register contents
- i_flush  in  1  load a bubble instead of MEM result
- i_valid  in  1  MEM slot holds a real instruction
- i_c_regWrite  in  1  instruction writes a GPR
- i_c_memToReg  in  1  write data comes from memory
- i_c_link  in  1  write data is the link address (jal/jalr)
- i_wrAddr  in  5  destination GPR index
- i_ALUres  in  32  ALU result; [1:0] is the load byte offset
- i_mem  in  32  raw word read from data memory
- i_link_pc  in  32  link address (PC+8)
- i_ld_size  in  2  0=byte, 1=half, 2=word, 3=reserved (treated as word)
- i_ld_unsigned  in  1  zero-extend instead of sign-extend
- i_exception  in  1  instruction in MEM raised an exception
- o_c_regWrite  out  1  register-file write enable
- o_wrAddr  out  5  register-file write address
- o_wrDataToReg  out  32  register-file write data / forwarding data
- o_wb_valid  out  1  WB slot holds a retiring instruction
- o_misaligned  out  1  one-cycle pulse: misaligned load squashed
- o_retired_cnt  out  CNT_W  retired instruction count

Behaviour:
- Reset (async, i_rst_n=0): all outputs 0; counter 0; slot empty. Reset mid-stall or mid-flush: same result. First capture occurs on the first rising edge after deassertion.
- Latency: one cycle. MEM inputs sampled on a rising edge appear on the outputs after that edge. All outputs are registered; there is no combinational input-to-output path.
- Priority at each edge: flush > stall > capture.
  - Flush: o_wb_valid=0, o_c_regWrite=0, o_misaligned=0. Address and data outputs are don't-care; hold them.
  - Stall: all outputs hold, except o_misaligned, which is cleared after one cycle.
  - Capture: proceeds normally.
- Data select: i_c_link -> i_link_pc; else i_c_memToReg -> extracted load; else i_ALUres.
- Load extraction (little-endian, off = i_ALUres[1:0]):
  - Byte: i_mem[8*off+7 : 8*off], extended to 32 bits.
  - Half: off=0 -> [15:0]; off=2 -> [31:16], extended to 32 bits.
  - Word: i_mem unchanged.
- Misalignment: half with off odd, or word with off != 0, and i_c_memToReg=1.
  - Captured with o_c_regWrite=0 and o_wb_valid=0.
  - o_misaligned=1 for exactly one cycle.
- Write enable: o_c_regWrite = i_valid & i_c_regWrite & !i_exception & !misaligned & (i_wrAddr != ZERO_REG).
- o_wb_valid = i_valid & !i_exception & !misaligned.
- Retire counter: +1 on each edge where a capture sets o_wb_valid=1. Wraps modulo 2^CNT_W. No increment on stall, flush or bubble.
- Stalled slot: never counted twice; its register write is asserted continuously (idempotent).

Optional Feature:
- Macro WB_RETIRE_CNT_EN.
- Defined: counter logic present as described above.
- Undefined: no counter flops; o_retired_cnt tied to 0. All other behaviour unchanged.

Test Plan:
- Reset: rst_n=0 while i_valid=1 -> all outputs 0. Release, ALU op addr 5, ALUres=0x1234 -> next cycle regWrite=1, addr=5, data=0x00001234, cnt=1.
- Signed byte load: mem=0x80FF7F01, off=2, size=0, unsigned=0 -> data=0xFFFFFFFF. Same inputs with unsigned=1 -> 0x000000FF.
- Half loads: mem=0x80FF7F01, off=2 -> data=0xFFFF80FF. Off=1 -> regWrite=0, o_misaligned pulses exactly one cycle, cnt unchanged.
- Link and zero register:
  - jal, link_pc=0x00400008, addr 31 -> data=0x00400008.
  - Write to addr 0 -> regWrite=0, wb_valid=1, cnt increments.
- Stall/flush/exception:
  - Stall 3 cycles -> outputs hold, cnt +1 total.
  - Stall and flush together -> bubble.
  - i_exception=1 -> regWrite=0, cnt unchanged.
- Counter wrap with CNT_W=8: 256 valid retires -> cnt returns to 0. With WB_RETIRE_CNT_EN undefined -> cnt constant 0.
